led_sequencer: RTL

Sequencing controller for the board's bicolour status LED. It sits between the combinational red/green request logic and the LED pins. It debounces the user button and decides when the LED is lit: dark, a timed button-triggered display, or a continuous charge display while USB power is present. It turns static requests into solid, slow-blink or alternating patterns from a shared tick prescaler.

---
 rtl/led_seq_pkg.sv | 13 +
 rtl/button_debounce.sv | 67 ++++++
 rtl/led_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the status LED sequencer.
// Imported by the sequencer top and its button debouncer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    CHARGE = 2'd2
  } led_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/button_debounce.sv
// Button synchroniser, tick-based debouncer and press pulse.
// A press needs a fresh 0->1 of the accepted level after reset.
module button_debounce
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   btn_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button};
    btn_s  = sync_q[SYNC_STAGES-1];
  end

  // Not reset, so a button held through reset is still seen as high.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (btn_s == acc_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        cnt_d = '0;
        acc_d = btn_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    armed_d = armed_q | (~acc_d & ~btn_s);
    press_d = acc_d & ~acc_q & armed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Bicolour status LED sequencer: prescaler, display FSM,
// blink phase generators and registered LED drive.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int SHOW_TICKS     = 3000,
  parameter int SLOW_HALF      = 500,
  parameter int FAST_HALF      = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic red_req,
  input  logic green_req,
  input  logic button,
  input  logic usb,
  input  logic stat,
  output logic red,
  output logic green,
  output logic active
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int HW = $clog2(SHOW_TICKS + 1);
  localparam int SW = $clog2(SLOW_HALF + 1);
  localparam int FW = $clog2(FAST_HALF + 1);

  logic [SYNC_STAGES-1:0][3:0] meta_q, meta_d;
  logic red_s, green_s, usb_s, stat_s;

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic          press;

  led_state_t    state_q, state_d;
  logic [HW-1:0] show_q, show_d;
  logic          phase_rst;

  logic [SW-1:0] slow_cnt_q, slow_cnt_d;
  logic          slow_ph_q, slow_ph_d;
  logic [FW-1:0] fast_cnt_q, fast_cnt_d;
  logic          fast_ph_q, fast_ph_d;

  logic red_q, red_d;
  logic green_q, green_d;
  logic active_q, active_d;

  always_comb begin
    meta_d = {meta_q[SYNC_STAGES-2:0], {red_req, green_req, usb, stat}};
    {red_s, green_s, usb_s, stat_s} = meta_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    meta_q <= meta_d;
  end

  always_comb begin
    tick  = (div_q == DW'(TICK_DIV - 1));
    div_d = tick ? '0 : div_q + DW'(1);
  end

  button_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .button(button),
    .press (press)
  );

  always_comb begin
    state_d = state_q;
    show_d  = show_q;
    unique case (state_q)
      IDLE: begin
        if (usb_s) begin
          state_d = CHARGE;
        end else if (press) begin
          state_d = SHOW;
          show_d  = HW'(SHOW_TICKS);
        end
      end
      SHOW: begin
        if (usb_s) begin
          state_d = CHARGE;
        end else if (press) begin
          show_d = HW'(SHOW_TICKS);
        end else if (show_q == '0) begin
          state_d = IDLE;
        end else if (tick) begin
          show_d = show_q - HW'(1);
        end
      end
      CHARGE: begin
        if (!usb_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Restart both phases ON whenever the display mode changes.
  always_comb begin
    phase_rst  = (state_d != state_q);
    slow_cnt_d = slow_cnt_q;
    slow_ph_d  = slow_ph_q;
    fast_cnt_d = fast_cnt_q;
    fast_ph_d  = fast_ph_q;
    if (phase_rst) begin
      slow_cnt_d = '0;
      slow_ph_d  = 1'b1;
      fast_cnt_d = '0;
      fast_ph_d  = 1'b1;
    end else if (tick) begin
      if (slow_cnt_q == SW'(SLOW_HALF - 1)) begin
        slow_cnt_d = '0;
        slow_ph_d  = ~slow_ph_q;
      end else begin
        slow_cnt_d = slow_cnt_q + SW'(1);
      end
      if (fast_cnt_q == FW'(FAST_HALF - 1)) begin
        fast_cnt_d = '0;
        fast_ph_d  = ~fast_ph_q;
      end else begin
        fast_cnt_d = fast_cnt_q + FW'(1);
      end
    end
  end

  always_comb begin
    red_d    = 1'b0;
    green_d  = 1'b0;
    active_d = (state_q != IDLE);
    if (state_q != IDLE) begin
      if (red_s && green_s) begin
        red_d   = fast_ph_q;
        green_d = ~fast_ph_q;
      end else if (state_q == SHOW || stat_s) begin
        red_d   = red_s;
        green_d = green_s;
      end else begin
        red_d   = red_s & slow_ph_q;
        green_d = green_s & slow_ph_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      state_q    <= IDLE;
      show_q     <= '0;
      slow_cnt_q <= '0;
      slow_ph_q  <= 1'b1;
      fast_cnt_q <= '0;
      fast_ph_q  <= 1'b1;
      red_q      <= 1'b0;
      green_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      state_q    <= state_d;
      show_q     <= show_d;
      slow_cnt_q <= slow_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_cnt_q <= fast_cnt_d;
      fast_ph_q  <= fast_ph_d;
      red_q      <= red_d;
      green_q    <= green_d;
      active_q   <= active_d;
    end
  end

  assign red    = red_q;
  assign green  = green_q;
  assign active = active_q;

endmodule
